// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared constants and types for the 98-input MLP datapath and its front end.
//   K    : window side (window is K x K pixels)
//   W_X  : pixel magnitude width in bits
//   N1   : first-layer input count, one magnitude and one polarity per pixel
//   pixel_t : one pixel as it travels through line buffers and the window
// -----------------------------------------------------------------------------
package mlp_pkg;

   localparam int K   = 7;
   localparam int W_X = 4;
   localparam int N1  = 2 * K * K;

   // Polarity sits above the magnitude so a packed pixel is {pol, mag}.
   typedef struct packed {
      logic           pol;
      logic [W_X-1:0] mag;
   } pixel_t;

endpackage

// File: rtl/mlp_line_buf.sv
// -----------------------------------------------------------------------------
// mlp_line_buf
// One image row of storage, DEPTH entries of PW bits, addressed by column.
// The read port is combinational and returns the contents before this
// cycle's write, so a chain of these shifts a column upward by one row per
// accepted pixel. Contents are deliberately not reset: the window logic never
// exposes a line-buffer entry that the current frame has not rewritten.
//   clk  : clock
//   we   : write enable (pixel accepted)
//   addr : column address shared by read and write
//   din  : pixel written at addr
//   dout : pixel previously stored at addr
// -----------------------------------------------------------------------------
module mlp_line_buf #(
   parameter int DEPTH = 32,
   parameter int PW    = 5,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [PW-1:0] din,
   output logic [PW-1:0] dout
);

   logic [PW-1:0] mem_r [DEPTH];

   assign dout = mem_r[addr];

   // Row storage write; the read above sees the old value in the same cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= din;
      end
   end

endmodule

// File: rtl/mlp_window_7x7.sv
// -----------------------------------------------------------------------------
// mlp_window_7x7
// Streams raster-order pixels and presents every complete K x K window to the
// downstream fully pipelined MLP, one cycle after the window's bottom-right
// pixel is accepted. No backpressure: every s_valid cycle is accepted.
//   clk, rst         : clock, asynchronous active-high reset
//   s_valid          : input pixel present
//   s_sof            : qualified pixel is row 0, col 0
//   s_mag, s_pol     : pixel magnitude and polarity (1 = negative)
//   m_valid          : m_mag/m_pol hold a complete window
//   m_mag[r*K+j]     : magnitude at window row r (0 = oldest), column j
//   m_pol[r*K+j]     : polarity at the same position
// -----------------------------------------------------------------------------
module mlp_window_7x7 #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int K     = mlp_pkg::K,
   parameter int W_X   = mlp_pkg::W_X
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   input  logic                     s_sof,
   input  logic [W_X-1:0]           s_mag,
   input  logic                     s_pol,
   output logic                     m_valid,
   output logic [K*K-1:0][W_X-1:0]  m_mag,
   output logic [K*K-1:0]           m_pol
);

   import mlp_pkg::*;

   localparam int PW = W_X + 1;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [CW-1:0] col_s;        // column of the pixel on the input this cycle
   logic [RW-1:0] row_s;        // row of the pixel on the input this cycle
   logic [CW-1:0] col_next_s;
   logic [RW-1:0] row_next_s;
   logic          win_hit_s;
   logic          m_valid_r;
   logic [PW-1:0] pix_s;
   logic [PW-1:0] lb_rd_s [K-1];
   logic [PW-1:0] win_r   [K][K];

   // Same layout as pixel_t: polarity above magnitude.
   assign pix_s = {s_pol, s_mag};

   // Pixel position, start-of-frame override and counter advance.
   always_comb begin
      col_s      = col_r;
      row_s      = row_r;
      col_next_s = col_r;
      row_next_s = row_r;
      win_hit_s  = 1'b0;
      if (s_valid && s_sof) begin
         col_s = {CW{1'b0}};
         row_s = {RW{1'b0}};
      end else begin
         col_s = col_r;
         row_s = row_r;
      end
      if (s_valid) begin
         if (col_s == CW'(IMG_W - 1)) begin
            col_next_s = {CW{1'b0}};
            if (row_s == RW'(IMG_H - 1)) begin
               row_next_s = {RW{1'b0}};
            end else begin
               row_next_s = row_s + 1'b1;
            end
         end else begin
            col_next_s = col_s + 1'b1;
            row_next_s = row_s;
         end
         // Only rows/cols already covered by this frame can complete a window,
         // which also keeps stale line-buffer rows out of valid windows.
         win_hit_s = (row_s >= RW'(K - 1)) && (col_s >= CW'(K - 1));
      end else begin
         col_next_s = col_r;
         row_next_s = row_r;
         win_hit_s  = 1'b0;
      end
   end

   // Line-buffer chain: the newest row enters at K-2 and rows move toward 0.
   for (genvar r = 0; r < K - 1; r++) begin : g_lb
      logic [PW-1:0] din_s;
      if (r == K - 2) begin : g_top
         assign din_s = pix_s;
      end else begin : g_mid
         assign din_s = lb_rd_s[r+1];
      end
      mlp_line_buf #(
         .DEPTH (IMG_W),
         .PW    (PW),
         .AW    (CW)
      ) u_lb (
         .clk  (clk),
         .we   (s_valid),
         .addr (col_s),
         .din  (din_s),
         .dout (lb_rd_s[r])
      );
   end

   // Position counters, window shift register and registered valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r     <= {CW{1'b0}};
         row_r     <= {RW{1'b0}};
         m_valid_r <= 1'b0;
         for (int r = 0; r < K; r++) begin
            for (int j = 0; j < K; j++) begin
               win_r[r][j] <= {PW{1'b0}};
            end
         end
      end else begin
         col_r     <= col_next_s;
         row_r     <= row_next_s;
         m_valid_r <= win_hit_s;
         if (s_valid) begin
            for (int r = 0; r < K; r++) begin
               for (int j = 0; j < K - 1; j++) begin
                  win_r[r][j] <= win_r[r][j+1];
               end
            end
            // Right-hand column: buffered rows above, the live pixel at the bottom.
            for (int r = 0; r < K - 1; r++) begin
               win_r[r][K-1] <= lb_rd_s[r];
            end
            win_r[K-1][K-1] <= pix_s;
         end
      end
   end

   // Flatten the window onto the MLP input ports.
   always_comb begin
      m_mag = '0;
      m_pol = '0;
      for (int r = 0; r < K; r++) begin
         for (int j = 0; j < K; j++) begin
            m_mag[r*K+j] = win_r[r][j][W_X-1:0];
            m_pol[r*K+j] = win_r[r][j][W_X];
         end
      end
   end

   assign m_valid = m_valid_r;

endmodule

// File: tb/tb_mlp_window_7x7.sv
module tb_mlp_window_7x7;

   localparam int IW = 32;
   localparam int IH = 32;
   localparam int K  = 7;
   localparam int WX = 4;
   localparam int NP = K * K;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   s_valid;
   logic                   s_sof;
   logic [WX-1:0]          s_mag;
   logic                   s_pol;
   logic                   m_valid;
   logic [NP-1:0][WX-1:0]  m_mag;
   logic [NP-1:0]          m_pol;

   mlp_window_7x7 #(.IMG_W(IW), .IMG_H(IH), .K(K), .W_X(WX)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_sof   (s_sof),
      .s_mag   (s_mag),
      .s_pol   (s_pol),
      .m_valid (m_valid),
      .m_mag   (m_mag),
      .m_pol   (m_pol)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int unsigned           tag;
      int unsigned           ord;
      logic [NP-1:0][WX-1:0] mag;
      logic [NP-1:0]         pol;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   // reference image of the current frame, filled by raster position
   logic [WX:0] img [IH][IW];
   int          mrow = 0;
   int          mcol = 0;

   int          win_seen = 0;
   int          first_ord = 0;
   logic [WX-1:0] first_m0, first_m48, v3_m48;
   logic        first_p0, first_p48;
   int          v3_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle; on accept, place the pixel in the frame image and
   // queue the window it completes (if any) for the cycle after the edge.
   task automatic drive(input logic v, input logic sof, input logic [WX-1:0] mg, input logic pl);
      exp_t e;
      int   r, c;
      s_valid = v;
      s_sof   = sof;
      s_mag   = mg;
      s_pol   = pl;
      if (v) begin
         if (sof) begin
            r = 0; c = 0;
         end else begin
            r = mrow; c = mcol;
         end
         img[r][c] = {pl, mg};
         if (r >= K - 1 && c >= K - 1) begin
            e.tag = cyc + 1;
            e.ord = r * IW + c + 1;
            for (int i = 0; i < K; i++) begin
               for (int j = 0; j < K; j++) begin
                  e.mag[i*K+j] = img[r-K+1+i][c-K+1+j][WX-1:0];
                  e.pol[i*K+j] = img[r-K+1+i][c-K+1+j][WX];
               end
            end
            q.push_back(e);
         end
         c++;
         if (c == IW) begin
            c = 0;
            r++;
            if (r == IH) r = 0;
         end
         mrow = r;
         mcol = c;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom));
   endtask

   // Send npix pixels of a frame from (0,0). bubbles: 0 none, 1 alternate,
   // 2 random. rnd_data selects random pixels instead of the fixed pattern.
   task automatic send(input int npix, input int bubbles, input bit sof_first, input bit rnd_data);
      logic [WX-1:0] mg;
      logic          pl;
      for (int p = 0; p < npix; p++) begin
         if (rnd_data) begin
            mg = 4'($urandom);
            pl = 1'($urandom);
         end else begin
            mg = 4'(p % 16);
            pl = 1'((p / IW) % 2);
         end
         drive(1'b1, sof_first && (p == 0), mg, pl);
         if (bubbles == 1) idle();
         else if (bubbles == 2 && $urandom_range(0, 3) == 0) idle();
      end
   endtask

   // Scoreboard monitor: every expected window must show up exactly in its cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid) begin
            if (q.size() == 0 || q[0].tag != cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               mon_e = q.pop_front();
               chk("win_mag", 256'(m_mag), 256'(mon_e.mag));
               chk("win_pol", 256'(m_pol), 256'(mon_e.pol));
               if (win_seen == 0) begin
                  first_ord = int'(mon_e.ord);
                  first_m0  = m_mag[0];
                  first_m48 = m_mag[48];
                  first_p0  = m_pol[0];
                  first_p48 = m_pol[48];
               end
               if (mon_e.ord == 231) begin
                  v3_seen++;
                  v3_m48 = m_mag[48];
               end
               win_seen++;
            end
         end else if (q.size() > 0 && q[0].tag <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_window: got 0 expected 1 (ord %0d)", q[0].ord);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1;
      s_valid = 1'b0; s_sof = 1'b0; s_mag = '0; s_pol = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 256'(m_valid), 256'(0));
      chk("reset_mag", 256'(m_mag), 256'(0));
      chk("reset_pol", 256'(m_pol), 256'(0));
      rst = 1'b0;

      // V1 continuous pattern frame (also covers the row-7 boundary)
      win_seen = 0; v3_seen = 0;
      send(IW * IH, 0, 1'b1, 1'b0);
      idle();
      chk("v1_count", 256'(win_seen), 256'(676));
      chk("v1_first_ord", 256'(first_ord), 256'(199));
      chk("v1_mag0", 256'(first_m0), 256'(0));
      chk("v1_mag48", 256'(first_m48), 256'(6));
      chk("v1_pol0", 256'(first_p0), 256'(0));
      chk("v1_pol48", 256'(first_p48), 256'(0));
      chk("v3_seen", 256'(v3_seen), 256'(1));
      chk("v3_mag48", 256'(v3_m48), 256'(6));

      // V2 alternate-cycle bubbles
      win_seen = 0;
      send(IW * IH, 1, 1'b1, 1'b0);
      idle();
      chk("v2_count", 256'(win_seen), 256'(676));
      chk("v2_first_ord", 256'(first_ord), 256'(199));

      // V4 reset mid-frame right after a valid window, then random frame
      send(300, 0, 1'b1, 1'b0);
      s_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("v4_async_valid", 256'(m_valid), 256'(0));
      chk("v4_async_mag", 256'(m_mag), 256'(0));
      chk("v4_async_pol", 256'(m_pol), 256'(0));
      q.delete();
      mrow = 0; mcol = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      win_seen = 0;
      send(IW * IH, 0, 1'b0, 1'b1);
      idle();
      chk("v4_count", 256'(win_seen), 256'(676));
      chk("v4_first_ord", 256'(first_ord), 256'(199));

      // V5 s_sof mid-frame at pixel 500, then a full pattern frame
      send(499, 0, 1'b1, 1'b1);
      idle();
      win_seen = 0;
      send(IW * IH, 0, 1'b1, 1'b0);
      idle();
      chk("v5_count", 256'(win_seen), 256'(676));
      chk("v5_first_ord", 256'(first_ord), 256'(199));

      // random data with random bubbles and stray unqualified s_sof
      win_seen = 0;
      send(IW * IH, 2, 1'b1, 1'b1);
      idle();
      idle();
      chk("rnd_count", 256'(win_seen), 256'(676));
      chk("queue_empty", 256'(q.size()), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mlp_window_7x7.md
MLP_WINDOW_7X7 -- requirements
Module: mlp_window_7x7

Interface
REQ-001 The block SHALL have parameter IMG_W, default 32, meaning image width in pixels (>= 7).
REQ-002 The block SHALL have parameter IMG_H, default 32, meaning image height in pixels (>= 7).
REQ-003 The block SHALL have parameter K, default 7, meaning window side, with N1 = 2*K*K = 98.
REQ-004 The block SHALL have parameter W_X, default 4, meaning pixel magnitude width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port s_valid, input, 1 bit: input pixel present this cycle.
REQ-008 The block SHALL have port s_sof, input, 1 bit: the qualified pixel is row 0, col 0.
REQ-009 The block SHALL have port s_mag, input, W_X bits: pixel magnitude.
REQ-010 The block SHALL have port s_pol, input, 1 bit: pixel polarity (1 = negative).
REQ-011 The block SHALL have port m_valid, output, 1 bit: window outputs are a complete KxK window.
REQ-012 The block SHALL have port m_mag, output, [K*K-1:0][W_X-1:0]: window magnitudes, feeding in_mag of the downstream 98-input MLP.
REQ-013 The block SHALL have port m_pol, output, [K*K-1:0]: window polarities, feeding in_pol.

Function
REQ-014 Every cycle with s_valid=1 SHALL be an accepted pixel; there is no backpressure, since the downstream MLP is fully pipelined.
REQ-015 Internal col counter (0..IMG_W-1) and row counter (0..IMG_H-1) SHALL give the position of each accepted pixel.
- col increments per accepted pixel.
- At IMG_W-1, col wraps to 0 and row increments.
- At (IMG_H-1, IMG_W-1), both wrap to (0,0).
REQ-016 An accepted pixel with s_sof=1 SHALL be taken as (0,0), whatever the counter state; the next pixel is (0,1).
REQ-017 s_sof with s_valid=0 SHALL be ignored.
REQ-018 (K-1) line buffers, each IMG_W entries of W_X+1 bits, SHALL hold the previous K-1 rows.
- On accept at column c: lb[K-2][c] <= new pixel, and lb[r][c] <= lb[r+1][c] for r < K-2.
- Reads of column c SHALL return the pre-write contents.
REQ-019 The KxK window register SHALL update on each accept:
- Each row shifts left: win[r][j] <= win[r][j+1].
- win[K-1][K-1] <= the new pixel.
- win[r][K-1] <= lb[r][c] for r < K-1.
REQ-020 m_mag[r*K+j] and m_pol[r*K+j] SHALL be driven directly from win[r][j].
- r = 0 is the top (oldest) row; j = 0 is the leftmost column.
- Index K*K-1 is the newest pixel.
REQ-021 m_valid SHALL be registered: it is 1 in the cycle after an accept where row >= K-1 and col >= K-1, and 0 otherwise.
REQ-022 Latency SHALL be 1 cycle from accepting pixel (R,C) to m_valid with the window covering rows R-6..R and cols C-6..C.
REQ-023 A cycle with s_valid=0 SHALL hold counters, line buffers and window, and SHALL drive m_valid=0 in the following cycle.
REQ-024 Windows SHALL never span a row boundary: m_valid=0 after accepts at col 0..K-2.
REQ-025 Each frame SHALL produce exactly (IMG_H-K+1)*(IMG_W-K+1) valid windows, i.e. 676 at the defaults.
REQ-026 Line-buffer contents left from a previous frame or from before an s_sof SHALL never appear under m_valid=1.

Reset
REQ-027 rst=1 SHALL asynchronously clear row, col, the window registers and m_valid to 0, giving m_mag=0 and m_pol=0.
REQ-028 Line buffers SHALL NOT be reset.
REQ-029 After rst is released mid-frame, the next accepted pixel SHALL be (0,0).

Structure
REQ-030 The constants W_X, K, N1 = 2*K*K and the pixel struct {pol, mag} SHALL live in the shared package mlp_pkg, which the MLP stages also use.
REQ-031 One sub-module, mlp_line_buf, SHALL implement a single IMG_W-deep register line buffer with read-before-write at a shared column address.
- K-1 instances are chained.
- Total RTL is 120-400 lines.

Verification
Stimulus for V1-V4: a 32x32 frame where pixel (R,C) has mag = (32R+C) mod 16 and pol = R[0].
REQ-032 V1 continuous frame: the first m_valid comes 1 cycle after accepting (6,6), the 199th pixel.
- m_mag[0] = 0 and m_mag[48] = 6; m_pol[0] = 0 and m_pol[48] = 0.
- 676 valid windows in total, each checked against a reference model.
REQ-033 V2 bubbles: s_valid toggles 1,0,1,0 over the V1 frame.
- Windows and their contents match V1 exactly.
- m_valid is never 1 after an idle cycle.
REQ-034 V3 row boundary: accepts at row 7, cols 0..5 give m_valid=0; the accept at (7,6) gives m_valid=1 with m_mag[48] = 230 mod 16 = 6.
REQ-035 V4 reset mid-frame: rst pulsed after pixel 300.
- m_valid, m_mag and m_pol are 0 immediately, without waiting for a clock edge.
- On restart from (0,0), the first valid window again follows the 199th pixel, with no stale data.
REQ-036 V5 s_sof mid-frame: s_sof at pixel 500, then a full 32x32 frame.
- No m_valid for the next 198 accepts.
- Exactly 676 valid windows, identical to V1.
